// File: rtl/soc_map_pkg.sv
// Address map, MMIO register offsets, UART status bit positions and UART state type.
// Shared by the memory/MMIO slave and its UART transmitter.
package soc_map_pkg;
    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    localparam logic [1:0] REG_UART_DATA = 2'd0;
    localparam logic [1:0] REG_UART_STAT = 2'd1;
    localparam logic [1:0] REG_GPIO      = 2'd2;
    localparam logic [1:0] REG_RSVD      = 2'd3;

    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_CNT_NZ = 3;
    localparam int STAT_OVF    = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/soc_mem_mmio_if.sv
// Core-side word bus: address/store strobe from the core, registered read data back.
// Latency: read data valid one cycle after the address; no backpressure.
interface soc_mem_mmio_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;

    modport master (output Address, output WriteData, output MemWrite, input ReadData);
    modport slave  (input Address, input WriteData, input MemWrite, output ReadData);
endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 serial transmitter, LSB first, registered line output (idle high).
// Latency: START begins the cycle after a byte is taken; o_rdy only in IDLE or final STOP cycle.
module uart_tx_8n1
    import soc_map_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_vld,
    input  logic [7:0] i_dat,
    output logic       o_rdy,
    output logic       o_tx,
    output logic       o_busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_t   r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_last;

    assign w_last = (r_baud == CW'(CLKS_PER_BIT - 1));
    assign o_rdy  = (r_state == IDLE) || ((r_state == STOP) && w_last);
    assign o_busy = (r_state != IDLE);
    assign o_tx   = r_tx;

    // r_tx is loaded with the level of the state being entered, so the line tracks the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_vld) begin
                        r_shift <= i_dat;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_last) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                DATA: begin
                    if (w_last) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                STOP: begin
                    if (w_last) begin
                        r_baud <= '0;
                        if (i_vld) begin
                            r_shift <= i_dat;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/soc_mem_mmio.sv
// Core bus slave: unified RAM below 0x8000_0000, UART TX FIFO/status and GPIO above it.
// Latency: ReadData one cycle after Address, writes take effect at the strobe edge; full FIFO drops bytes (sticky ovf).
module soc_mem_mmio
    import soc_map_pkg::*;
#(
    parameter int    RAM_WORDS    = 1024,
    parameter string MEM_INIT     = "",
    parameter int    FIFO_DEPTH   = 8,
    parameter int    CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    soc_mem_mmio_if.slave        bus,
    output logic                 uart_tx,
    output logic [7:0]           gpio_out
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0] r_ram [RAM_WORDS];
    logic [31:0] r_ram_q;
    logic [31:0] r_mmio_q;
    logic        r_sel_mmio;
    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;
    logic        r_ovf;
    logic [7:0]  r_gpio;

    logic [AW-1:0] w_idx;
    logic [1:0]    w_reg;
    logic          w_is_mmio;
    logic          w_wr_ram, w_wr_data, w_wr_stat, w_wr_gpio;
    logic          w_empty, w_full, w_pop, w_push;
    logic          w_uart_rdy, w_busy;
    logic [31:0]   w_mmio_rd;
    logic          w_unused;

    assign w_is_mmio = (bus.Address[31] == MMIO_BASE[31]);
    assign w_idx     = bus.Address[AW+1:2];
    assign w_reg     = bus.Address[3:2];
    assign w_unused  = ^{bus.Address[30:AW+2], bus.Address[1:0], RAM_BASE};

    assign w_wr_ram  = bus.MemWrite && !w_is_mmio;
    assign w_wr_data = bus.MemWrite && w_is_mmio && (w_reg == REG_UART_DATA);
    assign w_wr_stat = bus.MemWrite && w_is_mmio && (w_reg == REG_UART_STAT);
    assign w_wr_gpio = bus.MemWrite && w_is_mmio && (w_reg == REG_GPIO);

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    // Pop looks only at registered pointers, so a byte pushed this cycle is seen next cycle.
    assign w_pop   = w_uart_rdy && !w_empty;
    assign w_push  = w_wr_data && (!w_full || w_pop);

    always_comb begin
        w_mmio_rd = '0;
        case (w_reg)
            REG_UART_STAT: begin
                w_mmio_rd[STAT_OVF]    = r_ovf;
                w_mmio_rd[STAT_CNT_NZ] = !w_empty;
                w_mmio_rd[STAT_BUSY]   = w_busy;
                w_mmio_rd[STAT_EMPTY]  = w_empty;
                w_mmio_rd[STAT_FULL]   = w_full;
            end
            REG_GPIO:  w_mmio_rd[7:0] = r_gpio;
            default:   w_mmio_rd = '0;
        endcase
    end

    // RAM read sees the pre-write contents when the same word is written this cycle.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_idx] <= bus.WriteData;
        end
        r_ram_q <= r_ram[w_idx];
        if (w_push) begin
            r_fifo[r_wptr[PW-1:0]] <= bus.WriteData[7:0];
        end
    end

    // Reset selects the zeroed MMIO register so ReadData reads 0 without resetting the RAM port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_mmio <= 1'b1;
            r_mmio_q   <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ovf      <= 1'b0;
            r_gpio     <= '0;
        end else begin
            r_sel_mmio <= w_is_mmio;
            r_mmio_q   <= w_mmio_rd;
            if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
            if (w_wr_data && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_gpio) r_gpio <= bus.WriteData[7:0];
        end
    end

    assign bus.ReadData = r_sel_mmio ? r_mmio_q : r_ram_q;
    assign gpio_out     = r_gpio;

    uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk    (clk),
        .reset  (reset),
        .i_vld  (!w_empty),
        .i_dat  (r_fifo[r_rptr[PW-1:0]]),
        .o_rdy  (w_uart_rdy),
        .o_tx   (uart_tx),
        .o_busy (w_busy)
    );
endmodule
